// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave SRAM-like arbiter with locked grants and an in-order
// owner FIFO that steers each response back to the master that issued it.
module sram_like_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DATA_PRIO       = 1
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   m0_req,
  input  logic                                   m0_wr,
  input  logic [1:0]                             m0_size,
  input  logic [DATA_W/8-1:0]                    m0_wstrb,
  input  logic [ADDR_W-1:0]                      m0_addr,
  input  logic [DATA_W-1:0]                      m0_wdata,
  output logic                                   m0_addr_ok,
  output logic                                   m0_data_ok,
  output logic [DATA_W-1:0]                      m0_rdata,
  input  logic                                   m1_req,
  input  logic                                   m1_wr,
  input  logic [1:0]                             m1_size,
  input  logic [DATA_W/8-1:0]                    m1_wstrb,
  input  logic [ADDR_W-1:0]                      m1_addr,
  input  logic [DATA_W-1:0]                      m1_wdata,
  output logic                                   m1_addr_ok,
  output logic                                   m1_data_ok,
  output logic [DATA_W-1:0]                      m1_rdata,
  output logic                                   s_req,
  output logic                                   s_wr,
  output logic [1:0]                             s_size,
  output logic [DATA_W/8-1:0]                    s_wstrb,
  output logic [ADDR_W-1:0]                      s_addr,
  output logic [DATA_W-1:0]                      s_wdata,
  input  logic                                   s_addr_ok,
  input  logic                                   s_data_ok,
  input  logic [DATA_W-1:0]                      s_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   proto_err
);

  localparam int unsigned IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                       active_q;
  logic                       lock_q;
  logic                       lock_id_q;
  logic                       last_q;
  logic                       proto_err_q;
  logic [PTR_W-1:0]           wptr_q;
  logic [PTR_W-1:0]           rptr_q;
  logic [MAX_OUTSTANDING-1:0] owner_q;

  logic cand;
  logic cand_req;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic head;

  // Candidate: locked master first, then priority or round-robin on a tie.
  always_comb begin
    cand = 1'b0;
    if (lock_q) begin
      cand = lock_id_q;
    end else if (m0_req && m1_req) begin
      cand = (DATA_PRIO != 0) ? 1'b1 : ~last_q;
    end else begin
      cand = m1_req;
    end
  end

  assign cand_req   = cand ? m1_req : m0_req;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                      (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);

  // active_q drops asynchronously with reset so the request path is quiet in reset.
  assign s_req   = active_q & cand_req & ~fifo_full;
  assign push    = s_req & s_addr_ok;
  assign pop     = s_data_ok & ~fifo_empty;
  assign head    = owner_q[rptr_q[IDX_W-1:0]];

  assign s_wr    = cand ? m1_wr    : m0_wr;
  assign s_size  = cand ? m1_size  : m0_size;
  assign s_wstrb = cand ? m1_wstrb : m0_wstrb;
  assign s_addr  = cand ? m1_addr  : m0_addr;
  assign s_wdata = cand ? m1_wdata : m0_wdata;

  assign m0_addr_ok = push & ~cand;
  assign m1_addr_ok = push & cand;
  assign m0_data_ok = pop & ~head;
  assign m1_data_ok = pop & head;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  assign outstanding = CNT_W'(wptr_q - rptr_q);
  assign proto_err   = proto_err_q;

  // Lock, last-grant, owner FIFO and sticky error state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q    <= 1'b0;
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      last_q      <= 1'b0;
      proto_err_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      owner_q     <= '0;
    end else begin
      active_q  <= 1'b1;
      lock_q    <= s_req & ~s_addr_ok;
      lock_id_q <= cand;
      if (push) begin
        owner_q[wptr_q[IDX_W-1:0]] <= cand;
        wptr_q                     <= wptr_q + PTR_W'(1);
        last_q                     <= cand;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      if (s_data_ok && fifo_empty) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master to one-slave arbiter for the SRAM-like request interface (req / addr_ok / data_ok), placed between the pipeline's instruction-fetch and data-access ports and the single memory-side port. Master 0 is the instruction channel; master 1 is the data channel. Arbitration is fixed-priority or round-robin, and grants are locked until the address is accepted. An in-order owner FIFO routes each data_ok/rdata back to the master that issued the request, with up to MAX_OUTSTANDING requests in flight.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width, multiple of 8
- MAX_OUTSTANDING, 4, owner-FIFO depth; power of 2, at least 2
- DATA_PRIO, 1, 1 = master 1 always wins; 0 = round-robin

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  request valid
- m0_wr / m1_wr  in  1  1 = write
- m0_size / m1_size  in  2  0 = byte, 1 = half, 2 = word
- m0_wstrb / m1_wstrb  in  DATA_W/8  byte strobes
- m0_addr / m1_addr  in  ADDR_W  address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_addr_ok / m1_addr_ok  out  1  request accepted this cycle
- m0_data_ok / m1_data_ok  out  1  response for this master this cycle
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with data_ok
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  widths as above  muxed request to the slave
- s_addr_ok  in  1  slave accepts the request
- s_data_ok  in  1  slave response, in request order
- s_rdata  in  DATA_W  slave read data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  requests in flight
- proto_err  out  1  sticky flag: s_data_ok arrived while no request was outstanding

## Operation
- Candidate selection, no lock held: if only one master has req high, that master is the candidate. If both have req high:
  - DATA_PRIO=1: master 1 is the candidate.
  - DATA_PRIO=0: the master not granted last is the candidate. The last-grant register is initialised to 0, so master 1 wins the first tie.
- Lock register: set when s_req=1 and s_addr_ok=0. While set, the candidate is the locked master regardless of other requests. Cleared on the accepting handshake.
  - The locked master's req is protocol-required to stay high. If it drops anyway, the lock clears the next cycle.
- Issue condition: s_req = candidate req AND owner FIFO not full. All s_* request fields are a mux of the candidate's fields.
- Accept: when s_req && s_addr_ok, assert the candidate's mX_addr_ok, push the candidate's id to the owner FIFO, and update the last-grant register.
- Response: when s_data_ok, pop the FIFO head. Assert m{head}_data_ok for that cycle only.
  - Both mX_rdata outputs are always driven with s_rdata.
- Response with FIFO empty: set proto_err, do not pop, and assert no data_ok.
- Full FIFO: s_req stays 0 even if s_data_ok pops in the same cycle. This keeps data_ok off the req path.
- Simultaneous push and pop: allowed when not full; outstanding stays unchanged.
- outstanding = pushes - pops, range 0..MAX_OUTSTANDING.
- Pointer width is log2(MAX_OUTSTANDING)+1 bits. The extra MSB distinguishes full from empty; pointers wrap naturally.

## Timing
- While resetn=0, asynchronously:
  - FIFO empty, lock clear, last-grant = 0, proto_err = 0, outstanding = 0.
  - All m*/s_req/addr_ok/data_ok outputs are 0.
- Address phase is combinational, 0 added cycles: mX_req to s_req, and s_addr_ok to mX_addr_ok, in the same cycle.
- Response phase is combinational, 0 added cycles: s_data_ok to mX_data_ok in the same cycle. The owner id is a registered FIFO head.
- Throughput: one accept and one response per cycle, sustained.
- Reset asserted mid-operation discards all in-flight ownership. The slave must also be reset; a late s_data_ok after reset sets proto_err.
- proto_err clears only on reset.

## Test plan
- Single read: m0 reads 0x1C000000; slave addr_ok in the same cycle, data_ok 3 cycles later with 0xDEADBEEF. Required: m0_addr_ok and m0_data_ok each pulse once, m0_rdata = 0xDEADBEEF, m1_data_ok never asserts, outstanding goes 0, 1, 0.
- Contention, DATA_PRIO=1: both masters request continuously and slave addr_ok is always 1. Required: m1 is granted every cycle and m0 is starved. With DATA_PRIO=0, grants alternate m1, m0, m1, ...
- Lock: m0 requests while the slave holds addr_ok=0 for 4 cycles, and m1 raises req in cycle 2. Required: s_addr stays at m0's address until accept; m1 is granted the next cycle.
- Full: MAX_OUTSTANDING=4, 6 back-to-back requests, no responses. Required: exactly 4 addr_ok pulses and s_req=0 afterwards. One data_ok is then sent: s_req stays 0 that cycle and re-asserts the next cycle.
- Ordering: accepted order m1, m0, m1, with responses 0x11, 0x22, 0x33. Required: m1 gets 0x11, m0 gets 0x22, m1 gets 0x33.
- Error/reset: s_data_ok pulses while outstanding=0 → proto_err=1 and stays 1. Assert resetn=0 with 2 requests in flight → outstanding=0 and proto_err=0 immediately, without waiting for a clock edge.
